// File: rtl/pc_unit_if.sv
// Sequencing-control bundle between the opcode decoder and the PC unit.
// Latency: n/a (wires only); the PC unit registers everything it drives.
// Backpressure: stall freezes the PC unit; there is no valid/ready pair.
// Ports (master = decoder side, slave = pc_unit):
//   controls  : stall, halt, stPC, absJmp, branch[2:0], Retl, storeFlags,
//               flags_in[3:0] {N,C,Z,V}, target[ADDR_W-1:0]
//   responses : pc, halted, flags, stack_ovf, stack_unf, flush
interface pc_unit_if #(
  parameter int ADDR_W = 16
);
  logic              stall;
  logic              halt;
  logic              stPC;
  logic              absJmp;
  logic [2:0]        branch;
  logic              Retl;
  logic              storeFlags;
  logic [3:0]        flags_in;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic [3:0]        flags;
  logic              stack_ovf;
  logic              stack_unf;
  logic              flush;

  modport master (
    output stall, halt, stPC, absJmp, branch, Retl, storeFlags, flags_in, target,
    input  pc, halted, flags, stack_ovf, stack_unf, flush
  );

  modport slave (
    input  stall, halt, stPC, absJmp, branch, Retl, storeFlags, flags_in, target,
    output pc, halted, flags, stack_ovf, stack_unf, flush
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter / fetch sequencer with flags register, return stack and RUN/HALTED FSM.
// Latency: one cycle; controls seen in cycle n appear on pc after edge n+1.
// Backpressure: stall=1 holds pc, flags, stack and state; flush reads 0 the cycle after a stall.
// Ports: clk, rst (async, active high); bus (pc_unit_if.slave) carrying decoder
//   controls in and pc/halted/flags/stack_ovf/stack_unf/flush out.
// Optional: define PC_FLUSH_EN to generate the one-cycle redirect pulse on flush;
//   otherwise flush is tied low.
module pc_unit #(
  parameter int          ADDR_W       = 16,
  parameter int          STACK_DEPTH  = 8,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic     clk,
  input  logic     rst,
  pc_unit_if.slave bus
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0]   SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_VECTOR);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        flags_q, flags_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic              push_en;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] dest;
  logic [SP_W-1:0]   sp_m1;
  logic              take;
  logic              active;

  assign pc_inc = pc_q + ADDR_W'(1);
  // Relative jumps wrap modulo 2^ADDR_W; a negative offset is just its two's complement.
  assign dest   = bus.absJmp ? bus.target : (pc_q + bus.target);
  assign sp_m1  = sp_q - SP_W'(1);
  // An instruction only executes in RUN without stall; halt itself has no other effect.
  assign active = (state_q == ST_RUN) && !bus.stall && !bus.halt;

  // Condition uses the registered flags, so a same-cycle storeFlags is not visible.
  always_comb begin
    take = 1'b0;
    case (bus.branch)
      3'b000:  take = 1'b0;
      3'b001:  take = 1'b1;
      3'b010:  take = flags_q[1];
      3'b011:  take = !flags_q[1];
      3'b100:  take = flags_q[2];
      3'b101:  take = !flags_q[2];
      3'b110:  take = flags_q[3];
      3'b111:  take = flags_q[0];
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (state_q == ST_RUN && !bus.stall && bus.halt) begin
      state_d = ST_HALTED;
    end else if (active) begin
      if (bus.storeFlags) flags_d = bus.flags_in;
      if (bus.Retl) begin
        // Return wins over a simultaneous call; no push happens.
        if (sp_q != '0) begin
          pc_d = stack_q[sp_m1[IDX_W-1:0]];
          sp_d = sp_m1;
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (bus.stPC) begin
        pc_d = dest;
        // A full stack drops the return address but the call still jumps.
        if (sp_q != SP_FULL) begin
          push_en = 1'b1;
          sp_d    = sp_q + SP_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (take) begin
        pc_d = dest;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

`ifdef PC_FLUSH_EN
  logic flush_q, flush_d;
  // Redirect = any load other than pc+1; an underflowed return falls through.
  always_comb begin
    flush_d = 1'b0;
    if (active) begin
      if (bus.Retl) flush_d = (sp_q != '0);
      else          flush_d = bus.stPC || take;
    end
  end
  assign bus.flush = flush_q;
`else
  assign bus.flush = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RST_PC;
      flags_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifdef PC_FLUSH_EN
      flush_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`ifdef PC_FLUSH_EN
      flush_q <= flush_d;
`endif
    end
  end

  // Return-stack storage has no reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
  end

  assign bus.pc        = pc_q;
  assign bus.halted    = (state_q == ST_HALTED);
  assign bus.flags     = flags_q;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if #(.ADDR_W(16)) bus ();

  pc_unit #(.ADDR_W(16), .STACK_DEPTH(8), .RESET_VECTOR(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

`ifdef PC_FLUSH_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] ret [9];
  logic [15:0] cur;
  logic [15:0] tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.halt = 1'b0; bus.stPC = 1'b0; bus.absJmp = 1'b0;
    bus.branch = 3'b000; bus.Retl = 1'b0; bus.storeFlags = 1'b0;
    bus.flags_in = 4'h0; bus.target = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [15:0] epc, input bit redir);
    tick();
    chk(tag, bus.pc, epc);
    chk({tag, "_flush"}, bus.flush, FE & redir);
  endtask

  task automatic jmp(input logic [15:0] a);
    idle();
    bus.branch = 3'b001; bus.absJmp = 1'b1; bus.target = a;
    step("jmp", a, 1'b1);
    idle();
  endtask

  initial begin
    idle();
    #12;
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_flags", bus.flags, 4'h0);
    chk("rst_ovf", bus.stack_ovf, 1'b0);
    chk("rst_unf", bus.stack_unf, 1'b0);
    chk("rst_flush", bus.flush, 1'b0);
    rst = 1'b0;
    tick();

    // Async reset mid-run, then plain increments.
    jmp(16'h0042);
    rst = 1'b1;
    #1;
    chk("async_rst_pc", bus.pc, 16'h0000);
    #2;
    rst = 1'b0;
    step("inc1", 16'h0001, 1'b0);
    step("inc2", 16'h0002, 1'b0);
    step("inc3", 16'h0003, 1'b0);

    jmp(16'hFFFF);
    step("wrap", 16'h0000, 1'b0);

    // Stall freezes everything.
    jmp(16'h0010);
    bus.stall = 1'b1; bus.branch = 3'b001; bus.absJmp = 1'b1; bus.target = 16'h0077;
    bus.storeFlags = 1'b1; bus.flags_in = 4'hF;
    step("stall", 16'h0010, 1'b0);
    chk("stall_flags", bus.flags, 4'h0);
    idle();

    // Flags and relative branches.
    bus.storeFlags = 1'b1; bus.flags_in = 4'b0010;
    step("store_z", 16'h0011, 1'b0);
    chk("flags_z", bus.flags, 4'b0010);
    idle();
    bus.branch = 3'b010; bus.target = 16'hFFFC;
    step("bz_taken", 16'h000D, 1'b1);
    jmp(16'h0011);
    bus.branch = 3'b011; bus.target = 16'hFFFC;
    step("bnz_not", 16'h0012, 1'b0);
    idle();
    bus.storeFlags = 1'b1; bus.flags_in = 4'b1101; bus.branch = 3'b010;
    bus.absJmp = 1'b1; bus.target = 16'h0030;
    step("old_flags", 16'h0030, 1'b1);
    chk("flags_ncv", bus.flags, 4'b1101);
    idle();
    bus.absJmp = 1'b1; bus.target = 16'h0040; bus.branch = 3'b010;
    step("bz_not", 16'h0031, 1'b0);
    bus.branch = 3'b100;
    step("bc", 16'h0040, 1'b1);
    bus.branch = 3'b111; bus.target = 16'h0050;
    step("bv", 16'h0050, 1'b1);
    bus.branch = 3'b110; bus.absJmp = 1'b0; bus.target = 16'h0010;
    step("bn_rel", 16'h0060, 1'b1);
    bus.branch = 3'b101;
    step("bnc_not", 16'h0061, 1'b0);
    bus.branch = 3'b000;
    step("never", 16'h0062, 1'b0);

    // Call and return.
    jmp(16'h0020);
    bus.stPC = 1'b1; bus.absJmp = 1'b1; bus.target = 16'h0100;
    step("call", 16'h0100, 1'b1);
    idle();
    step("call_inc", 16'h0101, 1'b0);
    bus.Retl = 1'b1;
    step("ret", 16'h0021, 1'b1);

    // Overflow: nine calls into an eight-deep stack.
    jmp(16'h0200);
    cur = 16'h0200;
    for (int i = 0; i < 9; i++) begin
      ret[i] = cur + 16'h0001;
      tgt = 16'h0300 + 16'(i * 16);
      idle();
      bus.stPC = 1'b1; bus.absJmp = 1'b1; bus.target = tgt;
      step("ovf_call", tgt, 1'b1);
      chk("ovf_flag", bus.stack_ovf, (i == 8) ? 1'b1 : 1'b0);
      cur = tgt;
    end
    idle();
    bus.Retl = 1'b1;
    for (int k = 0; k < 8; k++) step("ovf_ret", ret[7 - k], 1'b1);
    chk("unf_before", bus.stack_unf, 1'b0);
    step("unf_ret", 16'h0202, 1'b0);
    chk("unf_after", bus.stack_unf, 1'b1);
    chk("ovf_sticky", bus.stack_ovf, 1'b1);

    // Simultaneous return and call: return wins, nothing pushed.
    jmp(16'h0054);
    bus.stPC = 1'b1; bus.absJmp = 1'b1; bus.target = 16'h0400;
    step("call2", 16'h0400, 1'b1);
    bus.Retl = 1'b1; bus.target = 16'h0500;
    step("ret_and_call", 16'h0055, 1'b1);
    idle();
    bus.Retl = 1'b1;
    step("no_push", 16'h0056, 1'b0);

    // Halt: stalled halt is ignored, then takes effect and freezes.
    idle();
    bus.halt = 1'b1; bus.stall = 1'b1;
    step("halt_stalled", 16'h0056, 1'b0);
    chk("halted_stalled", bus.halted, 1'b0);
    bus.stall = 1'b0; bus.branch = 3'b001; bus.absJmp = 1'b1; bus.target = 16'h0099;
    step("halt_edge", 16'h0056, 1'b0);
    chk("halted_set", bus.halted, 1'b1);
    bus.halt = 1'b0; bus.storeFlags = 1'b1; bus.flags_in = 4'h0;
    for (int i = 0; i < 5; i++) begin
      step("frozen", 16'h0056, 1'b0);
      chk("frozen_halted", bus.halted, 1'b1);
    end
    chk("frozen_flags", bus.flags, 4'b1101);
    rst = 1'b1;
    #1;
    chk("rst2_pc", bus.pc, 16'h0000);
    chk("rst2_halted", bus.halted, 1'b0);
    chk("rst2_flags", bus.flags, 4'h0);
    chk("rst2_ovf", bus.stack_ovf, 1'b0);
    chk("rst2_unf", bus.stack_unf, 1'b0);
    #2;
    rst = 1'b0;
    idle();
    step("post_rst", 16'h0001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter / fetch-sequencing stage directly upstream of the opcode decoder.
- Each cycle it consumes the decoder's sequencing controls (stPC, absJmp, branch, Retl, storeFlags, halt) plus the ALU flags and jump target, then produces the next PC that addresses instruction memory.
- Holds the flags register, a hardware return-address stack for call/return, and a RUN/HALTED state machine.

Parameters:
- ADDR_W, 16, PC and return-address width.
- STACK_DEPTH, 8, number of return-stack entries; power of two, minimum 2.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  freeze: no PC, flag, stack or state update this cycle.
- halt  in  1  decoder halt bit (control bit 24).
- stPC  in  1  call: push return address, then jump.
- absJmp  in  1  1 = target is an absolute address; 0 = target is a signed PC-relative offset.
- branch  in  3  branch condition select (encoding below).
- Retl  in  1  return: pop the stack into PC.
- storeFlags  in  1  latch flags_in into the flags register.
- flags_in  in  4  ALU flags {N,C,Z,V}; V is bit 0.
- target  in  ADDR_W  jump address or signed offset.
- pc  out  ADDR_W  current fetch address (registered).
- halted  out  1  1 while in the HALTED state.
- flags  out  4  registered flags.
- stack_ovf  out  1  sticky: push attempted while the stack was full.
- stack_unf  out  1  sticky: pop attempted while the stack was empty.
- flush  out  1  redirect pulse (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - pc = RESET_VECTOR; flags = 0; stack pointer sp = 0.
  - stack_ovf = stack_unf = 0; flush = 0; state = RUN; halted = 0.
  - Stack RAM contents are don't-care.
- States:
  - RUN: normal sequencing.
  - HALTED: pc, flags and stack are frozen; halted = 1. Only rst exits HALTED.
- Transition RUN -> HALTED:
  - Occurs on a clock edge where halt = 1 and stall = 0.
  - The instruction carrying halt takes no other effect: pc is not updated, and there is no push, pop or flag latch.
- When stall = 1 in RUN, everything holds and flush = 0.
- Branch condition (evaluated on the registered flags, before this cycle's storeFlags latch):
  - 000 never; 001 always
  - 010 Z; 011 !Z
  - 100 C; 101 !C
  - 110 N; 111 V
- Jump destination dest:
  - absJmp = 1: dest = target.
  - absJmp = 0: dest = pc + target, modulo 2^ADDR_W (wraps around).
- Next-PC priority, RUN, no stall:
  1. Retl = 1:
     - sp > 0: pc = stack[sp-1]; sp decrements.
     - sp = 0: pc = pc + 1; stack_unf sets.
     - stPC is ignored; no push.
  2. stPC = 1 (unconditional call): push pc + 1, then pc = dest.
     - sp < STACK_DEPTH: stack[sp] = pc + 1; sp increments.
     - sp = STACK_DEPTH: the push is dropped, stack_ovf sets, and pc = dest anyway.
  3. branch condition true: pc = dest.
  4. Otherwise: pc = pc + 1; wraps from 2^ADDR_W - 1 to 0.
- Flags:
  - storeFlags = 1 latches flags_in on the same edge as the PC update.
  - A branch in the same instruction sees the old flags.
- Latency: one cycle; controls presented in cycle n appear in pc at edge n+1.
- stack_ovf and stack_unf remain set until rst.
- sp range is 0..STACK_DEPTH, so its width is clog2(STACK_DEPTH) + 1.

Optional Feature:
- Macro: PC_FLUSH_EN.
- Defined:
  - flush is a registered one-cycle pulse, high in the cycle after any edge where pc loaded something other than pc + 1.
  - Such loads are a taken branch, a call, or a successful return.
  - An underflowed return (pc = pc + 1) does not pulse.
  - Downstream stages use flush to squash the wrongly fetched instruction.
- Not defined: flush is tied to 0 and the redirect-detect logic is omitted.

Test Plan:
- Reset and increment: assert rst mid-run with pc = 0x0042, then release; no controls for 3 cycles -> pc = 0x0000, 0x0001, 0x0002, 0x0003.
- Relative branch on flags:
  - Step 1: storeFlags = 1 with flags_in = 4'b0010 (Z set) at pc = 0x0010.
  - Step 2: next cycle, branch = 010, absJmp = 0, target = 0xFFFC -> pc = 0x000D.
  - With branch = 011 under the same flags, pc = 0x0012 instead.
- Call and return: at pc = 0x0020, stPC = 1, absJmp = 1, target = 0x0100 -> pc = 0x0100 and sp = 1. Later Retl = 1 -> pc = 0x0021 and sp = 0. With PC_FLUSH_EN, flush pulses after each redirect.
- Stack overflow: 9 consecutive calls with STACK_DEPTH = 8 -> stack_ovf = 1 after the 9th and pc = target. Then 8 returns restore the return addresses in reverse order, and a 9th return sets stack_unf with pc = pc + 1.
- Halt with stall:
  - Step 1: halt = 1 with stall = 1 -> state stays RUN and pc holds.
  - Step 2: stall drops -> halted = 1 and pc is frozen for 5 cycles despite branch = 001.
  - Step 3: rst -> pc = RESET_VECTOR and halted = 0.
- Simultaneous Retl + stPC with sp = 1 and stack[0] = 0x0055 -> pc = 0x0055, sp = 0, no push.
